// File: rtl/axi_regs_pkg.sv
// rtl/axi_regs_pkg.sv - shared constants and helpers for the axi_regs_bank register file
package axi_regs_pkg;

  localparam int          REG_W     = 32;
  localparam logic [31:0] REG_RESET = 32'h0;
  localparam logic [31:0] OOR_RDATA = 32'h0;

  // Default interrupt status index: second-to-last register.
  function automatic int irq_stat_index(input int cnt);
    return cnt - 2;
  endfunction

  // Default interrupt mask index: last register.
  function automatic int irq_mask_index(input int cnt);
    return cnt - 1;
  endfunction

  // Expand four byte strobes into a 32-bit bit mask.
  function automatic logic [REG_W-1:0] strobe_mask(input logic [3:0] stb);
    logic [REG_W-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{stb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_regs_irq.sv
// rtl/axi_regs_irq.sv - W1C interrupt status next-state and registered irq (used under AXI_REGS_BANK_IRQ_EN)
module axi_regs_irq
  import axi_regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en,
  input  logic [REG_W-1:0] wdata,
  input  logic [3:0]       wstb,
  input  logic [REG_W-1:0] irq_set,
  input  logic [REG_W-1:0] stat_q,
  input  logic [REG_W-1:0] mask_q,
  output logic [REG_W-1:0] stat_d,
  output logic             irq
);

  logic [REG_W-1:0] clr;
  logic             irq_d;
  logic             irq_q;

  // Status next state: clear strobed ones, then OR in new set pulses so set wins.
  always_comb begin
    clr    = '0;
    if (clr_en) begin
      clr = wdata & strobe_mask(wstb);
    end
    stat_d = (stat_q & ~clr) | irq_set;
    irq_d  = |(stat_q & mask_q);
  end

  // irq is registered from the current status, so it trails status by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/axi_regs_bank.sv
// rtl/axi_regs_bank.sv - BRAM-port register bank with hw updates; AXI_REGS_BANK_IRQ_EN adds W1C status/mask irq
module axi_regs_bank
  import axi_regs_pkg::*;
#(
  parameter int REGISTERS_CNT = 20,
  parameter int ADDR_BITS     = 16,
  parameter int IRQ_STAT_ADDR = irq_stat_index(REGISTERS_CNT),
  parameter int IRQ_MASK_ADDR = irq_mask_index(REGISTERS_CNT)
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic [ADDR_BITS-1:0]           bram_waddr,
  input  logic [31:0]                    bram_wdata,
  input  logic [3:0]                     bram_wstb,
  input  logic                           bram_wen,
  input  logic [ADDR_BITS-1:0]           bram_raddr,
  input  logic                           bram_ren,
  input  logic                           bram_regen,
  output logic [31:0]                    bram_rdata,
  input  logic                           hw_we,
  input  logic [ADDR_BITS-1:0]           hw_addr,
  input  logic [31:0]                    hw_wdata,
  output logic                           hw_conflict,
  input  logic [31:0]                    irq_set,
  output logic                           irq,
  output logic [32*REGISTERS_CNT-1:0]    regs_out
);

  localparam logic [ADDR_BITS-1:0] CNT_A = ADDR_BITS'(REGISTERS_CNT);

  logic [REG_W-1:0] regs_q [REGISTERS_CNT];
  logic [REG_W-1:0] regs_d [REGISTERS_CNT];
  logic [REG_W-1:0] latch_q, latch_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic             conflict_q, conflict_d;
  logic [REG_W-1:0] wmask;
  logic [REG_W-1:0] rd_word;
  logic [REG_W-1:0] stat_next;

`ifdef AXI_REGS_BANK_IRQ_EN
  logic stat_clr_en;

  assign stat_clr_en = bram_wen && (bram_waddr == ADDR_BITS'(IRQ_STAT_ADDR));

  axi_regs_irq u_irq (
    .clk     (aclk),
    .rst     (arst),
    .clr_en  (stat_clr_en),
    .wdata   (bram_wdata),
    .wstb    (bram_wstb),
    .irq_set (irq_set),
    .stat_q  (regs_q[IRQ_STAT_ADDR]),
    .mask_q  (regs_q[IRQ_MASK_ADDR]),
    .stat_d  (stat_next),
    .irq     (irq)
  );
`else
  logic unused_irq_set;

  assign unused_irq_set = ^irq_set;
  assign stat_next      = REG_RESET;
  assign irq            = 1'b0;
`endif

  // Register next state: hw write replaces the word, an AXI write to the same index overrides it.
  always_comb begin
    wmask = strobe_mask(bram_wstb);
    for (int k = 0; k < REGISTERS_CNT; k++) begin
      regs_d[k] = regs_q[k];
      if (hw_we && (hw_addr == ADDR_BITS'(k))) begin
        regs_d[k] = hw_wdata;
      end
      if (bram_wen && (bram_waddr == ADDR_BITS'(k))) begin
        regs_d[k] = (regs_q[k] & ~wmask) | (bram_wdata & wmask);
      end
    end
`ifdef AXI_REGS_BANK_IRQ_EN
    // Status is owned by the irq block: hw writes and plain AXI writes never land here.
    regs_d[IRQ_STAT_ADDR] = stat_next;
`endif
    conflict_d = bram_wen && hw_we && (bram_waddr == hw_addr) && (bram_waddr < CNT_A);
  end

  // Two-stage read: stage 1 samples the pre-edge register, stage 2 moves the old latch out.
  always_comb begin
    rd_word = OOR_RDATA;
    for (int k = 0; k < REGISTERS_CNT; k++) begin
      if (bram_raddr == ADDR_BITS'(k)) begin
        rd_word = regs_q[k];
      end
    end
    latch_d = bram_ren   ? rd_word : latch_q;
    rdata_d = bram_regen ? latch_q : rdata_q;
  end

  // State registers with synchronous reset clearing every register and the read pipeline.
  always_ff @(posedge aclk) begin
    if (arst) begin
      for (int k = 0; k < REGISTERS_CNT; k++) begin
        regs_q[k] <= REG_RESET;
      end
      latch_q    <= REG_RESET;
      rdata_q    <= REG_RESET;
      conflict_q <= 1'b0;
    end else begin
      for (int k = 0; k < REGISTERS_CNT; k++) begin
        regs_q[k] <= regs_d[k];
      end
      latch_q    <= latch_d;
      rdata_q    <= rdata_d;
      conflict_q <= conflict_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < REGISTERS_CNT; g++) begin : g_out
      assign regs_out[32*g +: 32] = regs_q[g];
    end
  endgenerate

  assign bram_rdata  = rdata_q;
  assign hw_conflict = conflict_q;

endmodule

// File: tb/tb_axi_regs_bank.sv
// tb/tb_axi_regs_bank.sv - self-checking bench for axi_regs_bank (follows AXI_REGS_BANK_IRQ_EN if defined)
module tb_axi_regs_bank;

  localparam int CNT  = 20;
  localparam int AB   = 16;
  localparam int STAT = 18;
  localparam int MASK = 19;
`ifdef AXI_REGS_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              aclk;
  logic              arst;
  logic [AB-1:0]     bram_waddr;
  logic [31:0]       bram_wdata;
  logic [3:0]        bram_wstb;
  logic              bram_wen;
  logic [AB-1:0]     bram_raddr;
  logic              bram_ren;
  logic              bram_regen;
  logic [31:0]       bram_rdata;
  logic              hw_we;
  logic [AB-1:0]     hw_addr;
  logic [31:0]       hw_wdata;
  logic              hw_conflict;
  logic [31:0]       irq_set;
  logic              irq;
  logic [32*CNT-1:0] regs_out;

  axi_regs_bank #(.REGISTERS_CNT(CNT), .ADDR_BITS(AB)) dut (
    .aclk        (aclk),
    .arst        (arst),
    .bram_waddr  (bram_waddr),
    .bram_wdata  (bram_wdata),
    .bram_wstb   (bram_wstb),
    .bram_wen    (bram_wen),
    .bram_raddr  (bram_raddr),
    .bram_ren    (bram_ren),
    .bram_regen  (bram_regen),
    .bram_rdata  (bram_rdata),
    .hw_we       (hw_we),
    .hw_addr     (hw_addr),
    .hw_wdata    (hw_wdata),
    .hw_conflict (hw_conflict),
    .irq_set     (irq_set),
    .irq         (irq),
    .regs_out    (regs_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return regs_out[32*k +: 32];
  endfunction

  // Reference model of the bank's behaviour.
  logic [31:0] m_reg [CNT];
  logic [31:0] m_latch, m_rdata;
  logic        m_conf, m_irq;

  always @(posedge aclk) begin : model
    logic [31:0] old [CNT];
    logic [31:0] clr;
    int wa, ha, ra;
    if (arst) begin
      for (int k = 0; k < CNT; k++) m_reg[k] = 32'h0;
      m_latch = 0; m_rdata = 0; m_conf = 0; m_irq = 0;
    end else begin
      for (int k = 0; k < CNT; k++) old[k] = m_reg[k];
      wa = int'(bram_waddr); ha = int'(hw_addr); ra = int'(bram_raddr);
      if (bram_regen) m_rdata = m_latch;
      if (bram_ren) m_latch = (ra < CNT) ? old[ra] : 32'h0;
      m_conf = bram_wen && hw_we && (wa == ha) && (wa < CNT);
      m_irq  = IRQ_EN && ((old[STAT] & old[MASK]) != 0);
      if (hw_we && ha < CNT && !m_conf && !(IRQ_EN && ha == STAT)) m_reg[ha] = hw_wdata;
      clr = 0;
      if (bram_wen && wa < CNT) begin
        for (int b = 0; b < 4; b++) begin
          if (bram_wstb[b]) begin
            if (IRQ_EN && wa == STAT) clr[8*b +: 8] = bram_wdata[8*b +: 8];
            else m_reg[wa][8*b +: 8] = bram_wdata[8*b +: 8];
          end
        end
      end
      if (IRQ_EN) m_reg[STAT] = (old[STAT] & ~clr) | irq_set;
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge aclk) begin
    if (chk_en) begin
      for (int k = 0; k < CNT; k++) check($sformatf("model_reg%0d", k), word(k), m_reg[k]);
      check("model_rdata", bram_rdata, m_rdata);
      check("model_conflict", {31'b0, hw_conflict}, {31'b0, m_conf});
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idle();
    bram_waddr = 0; bram_wdata = 0; bram_wstb = 0; bram_wen = 0;
    bram_raddr = 0; bram_ren = 0; bram_regen = 0;
    hw_we = 0; hw_addr = 0; hw_wdata = 0; irq_set = 0;
  endtask

  task automatic axi_wr(input int a, input logic [31:0] d, input logic [3:0] s);
    bram_wen = 1; bram_waddr = AB'(a); bram_wdata = d; bram_wstb = s;
  endtask

  logic [32*CNT-1:0] snap;

  initial begin
    idle();
    arst = 1'b1;
    @(negedge aclk);
    tick();
    chk_en = 1'b1;
    tick();
    arst = 1'b0;

    // Reset state.
    for (int k = 0; k < CNT; k++) check($sformatf("reset_reg%0d", k), word(k), 32'h0);
    check("reset_rdata", bram_rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_conflict", {31'b0, hw_conflict}, 32'h0);

    // Read every index pipelined; rdata must stay zero.
    for (int i = 0; i <= CNT; i++) begin
      bram_ren = (i < CNT); bram_raddr = AB'(i); bram_regen = (i > 0);
      tick();
      check("reset_readback", bram_rdata, 32'h0);
    end
    idle();

    // Byte-strobed writes to index 3.
    axi_wr(3, 32'hA5A5A5A5, 4'hF);
    tick();
    check("wr_full", word(3), 32'hA5A5A5A5);
    axi_wr(3, 32'h11223344, 4'b0101);
    tick();
    check("wr_strobe", regs_out[127:96], 32'hA522A544);
    idle();
    bram_ren = 1; bram_raddr = 3;
    tick();
    idle();
    bram_regen = 1;
    tick();
    idle();
    check("rd_idx3", bram_rdata, 32'hA522A544);

    // AXI vs hw conflict on index 5, then lone hw write to 6.
    axi_wr(5, 32'h1, 4'hF);
    hw_we = 1; hw_addr = 5; hw_wdata = 32'h2;
    tick();
    idle();
    check("conflict_reg5", word(5), 32'h1);
    check("conflict_pulse", {31'b0, hw_conflict}, 32'h1);
    tick();
    check("conflict_drop", {31'b0, hw_conflict}, 32'h0);
    hw_we = 1; hw_addr = 6; hw_wdata = 32'h7;
    tick();
    idle();
    check("hw_reg6", word(6), 32'h7);
    check("hw_noconflict", {31'b0, hw_conflict}, 32'h0);

    // Out-of-range write and read.
    snap = regs_out;
    axi_wr(25, 32'hFFFFFFFF, 4'hF);
    hw_we = 1; hw_addr = 25; hw_wdata = 32'hDEADBEEF;
    tick();
    idle();
    check("oor_conflict", {31'b0, hw_conflict}, 32'h0);
    for (int k = 0; k < CNT; k++) check($sformatf("oor_reg%0d", k), word(k), snap[32*k +: 32]);
    bram_ren = 1; bram_raddr = 25;
    tick();
    idle();
    bram_regen = 1;
    tick();
    idle();
    check("oor_rdata", bram_rdata, 32'h0);

    if (IRQ_EN) begin
      axi_wr(MASK, 32'h4, 4'hF);
      tick();
      idle();
      check("irq_mask", word(MASK), 32'h4);
      irq_set = 32'h4;
      tick();
      idle();
      check("irq_stat_set", word(STAT), 32'h4);
      check("irq_lag", {31'b0, irq}, 32'h0);
      tick();
      check("irq_high", {31'b0, irq}, 32'h1);
      axi_wr(STAT, 32'h4, 4'hF);
      irq_set = 32'h4;
      tick();
      idle();
      check("irq_set_wins", word(STAT), 32'h4);
      axi_wr(STAT, 32'h4, 4'hF);
      tick();
      idle();
      check("irq_w1c", word(STAT), 32'h0);
      check("irq_still", {31'b0, irq}, 32'h1);
      tick();
      check("irq_low", {31'b0, irq}, 32'h0);
    end else begin
      irq_set = 32'h4;
      tick();
      idle();
      check("noirq_stat", word(STAT), 32'h0);
      tick();
      check("noirq_line", {31'b0, irq}, 32'h0);
      hw_we = 1; hw_addr = AB'(STAT); hw_wdata = 32'h55;
      tick();
      idle();
      check("noirq_hw_stat", word(STAT), 32'h55);
    end

    // Back-to-back overlapped reads of 1, 2, 3.
    axi_wr(1, 32'h0000_1111, 4'hF);
    tick();
    axi_wr(2, 32'h0000_2222, 4'hF);
    tick();
    idle();
    bram_ren = 1; bram_raddr = 1;
    tick();
    bram_raddr = 2; bram_regen = 1;
    tick();
    check("b2b_r1", bram_rdata, 32'h0000_1111);
    bram_raddr = 3;
    tick();
    check("b2b_r2", bram_rdata, 32'h0000_2222);
    bram_ren = 0;
    tick();
    check("b2b_r3", bram_rdata, 32'hA522A544);
    idle();

    // Reset in the middle of a read.
    bram_ren = 1; bram_raddr = 3;
    tick();
    idle();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    bram_regen = 1;
    tick();
    idle();
    check("reset_midread", bram_rdata, 32'h0);
    check("reset_mid_reg3", word(3), 32'h0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
